// File: rtl/life_pkg.sv
// Shared types and constants for the life grid engine: FSM states, Conway rule masks
// and flat grid indexing.
package life_pkg;

    typedef enum logic [0:0] {
        S_IDLE,
        S_COMMIT
    } state_e;

    localparam logic [8:0] RULE_CONWAY_B = 9'b0_0000_1000;
    localparam logic [8:0] RULE_CONWAY_S = 9'b0_0000_1100;

    // Bit r*cols+c of the flat board holds cell (r,c).
    function automatic int unsigned idx(int unsigned r, int unsigned c, int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_cell.sv
// One automaton cell: counts live neighbours and applies the birth/survive masks.
// Purely combinational; the board register lives in the top.
module life_cell
    import life_pkg::*;
#(
    parameter logic [8:0] BIRTH_MASK   = RULE_CONWAY_B,
    parameter logic [8:0] SURVIVE_MASK = RULE_CONWAY_S
) (
    input  logic [7:0] nbrs_i,
    input  logic       alive_i,
    output logic       next_o
);

    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, nbrs_i[i]};
        end
        next_o = alive_i ? SURVIVE_MASK[count] : BIRTH_MASK[count];
    end

endmodule

// File: rtl/life_grid_engine.sv
// ROWS x COLS cellular automaton: holds the board, commits one generation per accepted
// step (manual or prescaled auto-step) and supports row-wise loading.
module life_grid_engine
    import life_pkg::*;
#(
    parameter int unsigned         ROWS         = 8,
    parameter int unsigned         COLS         = 8,
    parameter int unsigned         WRAP         = 0,
    parameter logic [8:0]          BIRTH_MASK   = RULE_CONWAY_B,
    parameter logic [8:0]          SURVIVE_MASK = RULE_CONWAY_S,
    parameter int unsigned         PERIOD       = 25_000_000,
    parameter int unsigned         GEN_W        = 16,
    parameter logic [ROWS*COLS-1:0] INIT        = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     step_valid,
    output logic                     step_ready,
    input  logic                     load_valid,
    input  logic [$clog2(ROWS)-1:0]  load_row,
    input  logic [COLS-1:0]          load_data,
    output logic                     load_ready,
    output logic [ROWS*COLS-1:0]     grid,
    output logic [GEN_W-1:0]         generation,
    output logic                     stable,
    output logic                     extinct
);

    localparam int unsigned    RW        = $clog2(ROWS);
    localparam int unsigned    PW        = $clog2(PERIOD);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PERIOD - 1);

    state_e               state_q, state_d;
    logic [ROWS*COLS-1:0] grid_q, grid_d;
    logic [GEN_W-1:0]     gen_q, gen_d;
    logic                 stable_q, stable_d;
    logic                 extinct_q, extinct_d;
    logic [PW-1:0]        presc_q, presc_d;

    logic [ROWS*COLS-1:0] grid_next;
    logic [ROWS*COLS-1:0] grid_load;
    logic [ROWS+1:0][COLS+1:0] pad;
    logic                 tick;
    logic                 step_go;
    logic                 load_go;

    // Board surrounded by a one-cell border: dead cells, or the opposite edge when wrapping.
    for (genvar pr = 0; pr < ROWS + 2; pr++) begin : g_pad_r
        for (genvar pc = 0; pc < COLS + 2; pc++) begin : g_pad_c
            localparam int unsigned SR = (pr + ROWS - 1) % ROWS;
            localparam int unsigned SC = (pc + COLS - 1) % COLS;
            localparam bit BORDER = (pr == 0) || (pr == ROWS + 1) || (pc == 0) || (pc == COLS + 1);
            if (BORDER && WRAP == 0) begin : g_dead
                assign pad[pr][pc] = 1'b0;
            end else begin : g_live
                assign pad[pr][pc] = grid_q[idx(SR, SC, COLS)];
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam logic [RW-1:0] LR = RW'(r);
        assign grid_load[r*COLS +: COLS] = (load_row == LR) ? load_data : grid_q[r*COLS +: COLS];
        for (genvar c = 0; c < COLS; c++) begin : g_col
            life_cell #(
                .BIRTH_MASK  (BIRTH_MASK),
                .SURVIVE_MASK(SURVIVE_MASK)
            ) u_cell (
                .nbrs_i ({pad[r][c],     pad[r][c+1],   pad[r][c+2],
                          pad[r+1][c],                  pad[r+1][c+2],
                          pad[r+2][c],   pad[r+2][c+1], pad[r+2][c+2]}),
                .alive_i(pad[r+1][c+1]),
                .next_o (grid_next[idx(r, c, COLS)])
            );
        end
    end

    always_comb begin
        tick       = run && (presc_q == PRESC_MAX);
        load_ready = (state_q == S_IDLE);
        step_ready = load_ready && !load_valid;
        step_go    = step_ready && (step_valid || tick);
        load_go    = load_ready && load_valid && (32'(load_row) < ROWS);

        // Tick holds while busy; a tick lost to a load is simply dropped.
        if (!run) begin
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = (state_q == S_IDLE) ? '0 : presc_q;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_go) begin
                    grid_d    = grid_load;
                    gen_d     = '0;
                    stable_d  = 1'b0;
                    extinct_d = (grid_load == '0);
                end else if (step_go) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d   = S_IDLE;
                grid_d    = grid_next;
                gen_d     = gen_q + GEN_W'(1);
                stable_d  = (grid_next == grid_q);
                extinct_d = (grid_next == '0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grid_q    <= INIT;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= (INIT == '0);
            presc_q   <= '0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_q     <= gen_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
            presc_q   <= presc_d;
        end
    end

    assign grid       = grid_q;
    assign generation = gen_q;
    assign stable     = stable_q;
    assign extinct    = extinct_q;

endmodule
